img2col_tile_gen: RTL and testbench

- Parametrised im2col tile engine.
- Walks the virtual im2col matrix of one input tensor: rows are output positions (OUT*OUT), columns are K*K*C kernel taps.
- Issues tensor-memory reads with zero-padding, stride and tail masking, and assembles TILE x TILE data tiles for the downstream systolic GEMM array.
- Sits between tensor SRAM and the GEMM input buffer; replaces fixed-size address and data-collection logic with one runtime-configurable block.

---
 rtl/img2col_tile_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_img2col_tile_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/img2col_tile_gen.sv
// im2col tile engine: walks the virtual im2col matrix of one tensor and assembles
// TILE x TILE data tiles from tensor memory reads with padding, stride and tail masking.
module img2col_tile_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int TILE       = 4,
   parameter int DIM_W      = 8,
   parameter int CH_W       = 8,
   parameter int K_W        = 4,
   parameter int RD_LAT     = 1
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            i_start,
   input  logic [DIM_W-1:0]                cfg_in_size,
   input  logic [DIM_W-1:0]                cfg_out_size,
   input  logic [K_W-1:0]                  cfg_k,
   input  logic [CH_W-1:0]                 cfg_c,
   input  logic [3:0]                      cfg_stride,
   input  logic [3:0]                      cfg_pad,
   input  logic [ADDR_WIDTH-1:0]           cfg_base,
   output logic [ADDR_WIDTH-1:0]           o_mem_addr,
   output logic                            o_mem_req,
   input  logic [DATA_WIDTH-1:0]           i_mem_rdata,
   output logic [TILE*TILE*DATA_WIDTH-1:0] o_tile,
   output logic                            o_tile_valid,
   input  logic                            i_tile_ready,
   output logic [DIM_W*2-1:0]              o_tile_row,
   output logic [K_W*2+CH_W-1:0]           o_tile_col,
   output logic                            o_last_tile,
   output logic                            o_busy,
   output logic                            o_done
);

   localparam int NSLOT = TILE * TILE;
   localparam int IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int C_W   = (TILE > 1) ? $clog2(TILE) : 1;
   localparam int D_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int QW    = K_W*2 + CH_W + 1;
   localparam int PW    = DIM_W*2 + 1;
   localparam int SQW   = DIM_W*2;
   localparam int CHW   = CH_W + 1;
   localparam int MW    = DIM_W + 5;
   localparam int SW    = DIM_W + 7;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

   state_t r_state, w_state_next;

   logic [DIM_W-1:0]      r_in, r_out;
   logic [K_W-1:0]        r_k;
   logic [3:0]            r_s, r_pad;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [QW-1:0]         r_kkc;
   logic [PW-1:0]         r_npix;
   logic [SQW-1:0]        r_in_sq;

   // Row position (p, ox, ox*S, oy*S): working copy, and start of the current row tile.
   logic [PW-1:0]    r_p, r_p0;
   logic [DIM_W-1:0] r_ox, r_ox0;
   logic [MW-1:0]    r_oxs, r_oxs0, r_oys, r_oys0;
   // Column position (q, ch, ky, kx): working, tile start, and start of the next column tile.
   logic [QW-1:0]    r_q, r_q0, r_qn;
   logic [CHW-1:0]   r_ch, r_ch0, r_chn;
   logic [K_W-1:0]   r_ky, r_ky0, r_kyn, r_kx, r_kx0, r_kxn;

   logic [IDX_W-1:0]          r_slot;
   logic [C_W-1:0]            r_c;
   logic [D_W-1:0]            r_dcnt;
   logic [DIM_W*2-1:0]        r_rt;
   logic [K_W*2+CH_W-1:0]     r_ct;
   logic                      r_done;
   logic [RD_LAT-1:0]         r_pv, r_ppad;
   logic [RD_LAT-1:0][IDX_W-1:0] r_pidx;
   logic [NSLOT-1:0][DATA_WIDTH-1:0] r_tile;

   logic w_kx_wrap, w_ky_wrap, w_ox_wrap;
   logic [K_W-1:0]   w_kx_n, w_ky_n;
   logic [CHW-1:0]   w_ch_n;
   logic [QW-1:0]    w_q_n;
   logic [DIM_W-1:0] w_ox_n;
   logic [MW-1:0]    w_oxs_n, w_oys_n;
   logic [PW-1:0]    w_p_n;
   logic [SW-1:0]    w_iy, w_ix;
   logic             w_iy_ok, w_ix_ok, w_pad, w_last_slot, w_row_end;
   logic             w_last_ct, w_last_rt, w_final, w_hs;
   logic [ADDR_WIDTH-1:0] w_ch_off, w_row_off, w_addr;

   assign w_kx_wrap = (r_kx == r_k - K_W'(1));
   assign w_ky_wrap = (r_ky == r_k - K_W'(1));
   assign w_kx_n    = w_kx_wrap ? '0 : r_kx + K_W'(1);
   assign w_ky_n    = w_kx_wrap ? (w_ky_wrap ? '0 : r_ky + K_W'(1)) : r_ky;
   assign w_ch_n    = (w_kx_wrap && w_ky_wrap) ? r_ch + CHW'(1) : r_ch;
   assign w_q_n     = r_q + QW'(1);

   assign w_ox_wrap = (r_ox == r_out - DIM_W'(1));
   assign w_ox_n    = w_ox_wrap ? '0 : r_ox + DIM_W'(1);
   assign w_oxs_n   = w_ox_wrap ? '0 : r_oxs + MW'(r_s);
   assign w_oys_n   = w_ox_wrap ? r_oys + MW'(r_s) : r_oys;
   assign w_p_n     = r_p + PW'(1);

   // Coordinates are two's complement: the top bit flags a tap above/left of the image.
   assign w_iy    = SW'(r_oys) + SW'(r_ky) - SW'(r_pad);
   assign w_ix    = SW'(r_oxs) + SW'(r_kx) - SW'(r_pad);
   assign w_iy_ok = !w_iy[SW-1] && (w_iy < SW'(r_in));
   assign w_ix_ok = !w_ix[SW-1] && (w_ix < SW'(r_in));
   assign w_pad   = (r_p >= r_npix) || (r_q >= r_kkc) || !w_iy_ok || !w_ix_ok;

   assign w_ch_off  = ADDR_WIDTH'(r_ch) * ADDR_WIDTH'(r_in_sq);
   assign w_row_off = ADDR_WIDTH'(w_iy) * ADDR_WIDTH'(r_in);
   assign w_addr    = r_base + w_ch_off + w_row_off + ADDR_WIDTH'(w_ix);

   assign w_last_slot = (r_slot == IDX_W'(NSLOT-1));
   assign w_row_end   = (r_c == C_W'(TILE-1));
   assign w_last_ct   = (r_q0 + QW'(TILE)) >= r_kkc;
   assign w_last_rt   = (r_p0 + PW'(TILE)) >= r_npix;
   assign w_final     = w_last_ct && w_last_rt;
   assign w_hs        = (r_state == S_OUT) && i_tile_ready;

   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = r_done;
   assign o_tile     = r_tile;
   assign o_tile_row = r_rt;
   assign o_tile_col = r_ct;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      w_state_next = r_state;
      o_mem_req    = 1'b0;
      o_mem_addr   = '0;
      o_tile_valid = 1'b0;
      o_last_tile  = 1'b0;
      unique case (r_state)
         S_IDLE:  if (i_start) w_state_next = S_ISSUE;
         S_ISSUE: begin
            o_mem_req  = !w_pad;
            o_mem_addr = w_addr;
            if (w_last_slot) w_state_next = S_DRAIN;
         end
         S_DRAIN: if (r_dcnt == D_W'(RD_LAT-1)) w_state_next = S_OUT;
         S_OUT: begin
            o_tile_valid = 1'b1;
            o_last_tile  = w_final;
            if (i_tile_ready) w_state_next = w_final ? S_IDLE : S_ISSUE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: the tile buffer is small register storage and is reset with everything else,
   // so a reset leaves o_tile at zero rather than holding stale data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_in <= '0; r_out <= '0; r_k <= '0; r_s <= '0; r_pad <= '0; r_base <= '0;
         r_kkc <= '0; r_npix <= '0; r_in_sq <= '0;
         r_p <= '0; r_p0 <= '0; r_ox <= '0; r_ox0 <= '0;
         r_oxs <= '0; r_oxs0 <= '0; r_oys <= '0; r_oys0 <= '0;
         r_q <= '0; r_q0 <= '0; r_qn <= '0; r_ch <= '0; r_ch0 <= '0; r_chn <= '0;
         r_ky <= '0; r_ky0 <= '0; r_kyn <= '0; r_kx <= '0; r_kx0 <= '0; r_kxn <= '0;
         r_slot <= '0; r_c <= '0; r_dcnt <= '0; r_rt <= '0; r_ct <= '0; r_done <= 1'b0;
         r_pv <= '0; r_ppad <= '0; r_pidx <= '0; r_tile <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
         r_done <= w_hs && w_final;
         for (int i = RD_LAT-1; i > 0; i--) begin
            r_pv[i]   <= r_pv[i-1];
            r_ppad[i] <= r_ppad[i-1];
            r_pidx[i] <= r_pidx[i-1];
         end
         r_pv[0]   <= (r_state == S_ISSUE);
         r_ppad[0] <= w_pad;
         r_pidx[0] <= r_slot;

         unique case (r_state)
            S_IDLE: if (i_start) begin
               r_in <= cfg_in_size; r_out <= cfg_out_size; r_k <= cfg_k;
               r_s <= cfg_stride; r_pad <= cfg_pad; r_base <= cfg_base;
               r_kkc   <= QW'(cfg_k) * QW'(cfg_k) * QW'(cfg_c);
               r_npix  <= PW'(cfg_out_size) * PW'(cfg_out_size);
               r_in_sq <= SQW'(cfg_in_size) * SQW'(cfg_in_size);
               r_p <= '0; r_p0 <= '0; r_ox <= '0; r_ox0 <= '0;
               r_oxs <= '0; r_oxs0 <= '0; r_oys <= '0; r_oys0 <= '0;
               r_q <= '0; r_q0 <= '0; r_ch <= '0; r_ch0 <= '0;
               r_ky <= '0; r_ky0 <= '0; r_kx <= '0; r_kx0 <= '0;
               r_slot <= '0; r_c <= '0; r_rt <= '0; r_ct <= '0; r_tile <= '0;
            end
            S_ISSUE: begin
               r_dcnt <= '0;
               r_slot <= w_last_slot ? '0 : r_slot + IDX_W'(1);
               if (w_row_end) begin
                  r_c  <= '0;
                  r_q  <= r_q0;  r_ch  <= r_ch0;  r_ky  <= r_ky0;  r_kx  <= r_kx0;
                  r_qn <= w_q_n; r_chn <= w_ch_n; r_kyn <= w_ky_n; r_kxn <= w_kx_n;
                  r_p  <= w_p_n; r_ox  <= w_ox_n; r_oxs <= w_oxs_n; r_oys <= w_oys_n;
               end else begin
                  r_c <= r_c + C_W'(1);
                  r_q <= w_q_n; r_ch <= w_ch_n; r_ky <= w_ky_n; r_kx <= w_kx_n;
               end
            end
            S_DRAIN: r_dcnt <= r_dcnt + D_W'(1);
            S_OUT: if (i_tile_ready && !w_final) begin
               r_tile <= '0;
               if (w_last_ct) begin
                  r_ct <= '0;
                  r_rt <= r_rt + (DIM_W*2)'(1);
                  r_q0 <= '0; r_ch0 <= '0; r_ky0 <= '0; r_kx0 <= '0;
                  r_q  <= '0; r_ch  <= '0; r_ky  <= '0; r_kx  <= '0;
                  r_p0 <= r_p; r_ox0 <= r_ox; r_oxs0 <= r_oxs; r_oys0 <= r_oys;
               end else begin
                  r_ct <= r_ct + (K_W*2+CH_W)'(1);
                  r_q0 <= r_qn; r_ch0 <= r_chn; r_ky0 <= r_kyn; r_kx0 <= r_kxn;
                  r_q  <= r_qn; r_ch  <= r_chn; r_ky  <= r_kyn; r_kx  <= r_kxn;
                  r_p  <= r_p0; r_ox  <= r_ox0; r_oxs <= r_oxs0; r_oys <= r_oys0;
               end
            end
            default: ;
         endcase

         // Returns land only while no clear can happen (ISSUE/DRAIN).
         if (r_pv[RD_LAT-1])
            r_tile[r_pidx[RD_LAT-1]] <= r_ppad[RD_LAT-1] ? '0 : i_mem_rdata;
      end
   end

endmodule

// File: tb/tb_img2col_tile_gen.sv
// Randomised self-checking bench for img2col_tile_gen against a divide/modulo
// reference model of the im2col matrix and a fixed-latency tensor memory.
module tb_img2col_tile_gen;

   localparam int DW     = 8;
   localparam int AW     = 16;
   localparam int T      = 4;
   localparam int DIM_W  = 8;
   localparam int CH_W   = 8;
   localparam int K_W    = 4;
   localparam int RD_LAT = 3;
   localparam int TW     = T*T*DW;

   logic                clk, rstn, i_start, i_tile_ready;
   logic [DIM_W-1:0]    cfg_in_size, cfg_out_size;
   logic [K_W-1:0]      cfg_k;
   logic [CH_W-1:0]     cfg_c;
   logic [3:0]          cfg_stride, cfg_pad;
   logic [AW-1:0]       cfg_base, o_mem_addr;
   logic                o_mem_req, o_tile_valid, o_last_tile, o_busy, o_done;
   logic [DW-1:0]       i_mem_rdata;
   logic [TW-1:0]       o_tile;
   logic [DIM_W*2-1:0]  o_tile_row;
   logic [K_W*2+CH_W-1:0] o_tile_col;

   img2col_tile_gen #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TILE(T), .DIM_W(DIM_W),
      .CH_W(CH_W), .K_W(K_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rstn(rstn), .i_start(i_start),
      .cfg_in_size(cfg_in_size), .cfg_out_size(cfg_out_size), .cfg_k(cfg_k),
      .cfg_c(cfg_c), .cfg_stride(cfg_stride), .cfg_pad(cfg_pad), .cfg_base(cfg_base),
      .o_mem_addr(o_mem_addr), .o_mem_req(o_mem_req), .i_mem_rdata(i_mem_rdata),
      .o_tile(o_tile), .o_tile_valid(o_tile_valid), .i_tile_ready(i_tile_ready),
      .o_tile_row(o_tile_row), .o_tile_col(o_tile_col), .o_last_tile(o_last_tile),
      .o_busy(o_busy), .o_done(o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int m_in, m_out, m_k, m_c, m_s, m_p, m_base;
   int req_cnt, done_cnt;
   logic [AW-1:0] addr_q[$];
   logic [TW-1:0] tile00;

   task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      logic [AW-1:0] t;
      t = a ^ (a >> 8);
      return t[DW-1:0];
   endfunction

   // Reference: element (r,c) of tile (rt,ct) straight from the im2col definition.
   task automatic model_tile(input int rt, input int ct, output logic [TW-1:0] t, output int nreq);
      int p, q, oy, ox, ch, ky, kx, iy, ix, addr;
      t = '0;
      nreq = 0;
      for (int r = 0; r < T; r++) begin
         for (int c = 0; c < T; c++) begin
            p = rt*T + r;
            q = ct*T + c;
            if (p >= m_out*m_out || q >= m_k*m_k*m_c) continue;
            oy = p / m_out;       ox = p % m_out;
            ch = q / (m_k*m_k);   ky = (q % (m_k*m_k)) / m_k;   kx = q % m_k;
            iy = oy*m_s + ky - m_p;
            ix = ox*m_s + kx - m_p;
            if (iy < 0 || iy >= m_in || ix < 0 || ix >= m_in) continue;
            addr = m_base + ch*m_in*m_in + iy*m_in + ix;
            t[(r*T+c)*DW +: DW] = mem_f(AW'(addr));
            nreq++;
         end
      end
   endtask

   // Tensor memory: returns data exactly RD_LAT cycles after a request, junk otherwise.
   logic [AW-1:0] h_addr [RD_LAT+1] = '{default: '0};
   logic          h_req  [RD_LAT+1] = '{default: 1'b0};
   always @(negedge clk) begin
      for (int i = RD_LAT; i > 0; i--) begin
         h_addr[i] = h_addr[i-1];
         h_req[i]  = h_req[i-1];
      end
      h_addr[0] = o_mem_addr;
      h_req[0]  = o_mem_req;
      i_mem_rdata = h_req[RD_LAT] ? mem_f(h_addr[RD_LAT]) : 8'hEE;
      if (o_mem_req) begin
         req_cnt++;
         addr_q.push_back(o_mem_addr);
      end
      if (o_done) done_cnt++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_cfg(input int in_s, input int out_s, input int k, input int c,
                          input int s, input int p, input int base);
      m_in = in_s; m_out = out_s; m_k = k; m_c = c; m_s = s; m_p = p; m_base = base;
      cfg_in_size = DIM_W'(in_s); cfg_out_size = DIM_W'(out_s); cfg_k = K_W'(k);
      cfg_c = CH_W'(c); cfg_stride = 4'(s); cfg_pad = 4'(p); cfg_base = AW'(base);
   endtask

   task automatic wait_valid(output bit ok);
      int n = 0;
      while (!o_tile_valid && n < 400) begin
         tick();
         n++;
      end
      ok = o_tile_valid;
   endtask

   task automatic run_job(input int stall_min, input int stall_max, input bit poke);
      int nrt, nct, nreq, stall;
      bit ok, last;
      logic [TW-1:0] exp;
      nrt = (m_out*m_out + T - 1) / T;
      nct = (m_k*m_k*m_c + T - 1) / T;
      req_cnt = 0;
      done_cnt = 0;
      addr_q.delete();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int rt = 0; rt < nrt; rt++) begin
         for (int ct = 0; ct < nct; ct++) begin
            last = (rt == nrt-1) && (ct == nct-1);
            wait_valid(ok);
            if (!ok) begin
               check("tile_valid_timeout", TW'(o_tile_valid), TW'(1));
               return;
            end
            model_tile(rt, ct, exp, nreq);
            if (rt == 0 && ct == 0) tile00 = o_tile;
            check("tile_data", o_tile, exp);
            check("tile_row", TW'(o_tile_row), TW'(rt));
            check("tile_col", TW'(o_tile_col), TW'(ct));
            check("last_tile", TW'(o_last_tile), TW'(last));
            check("req_count", TW'(req_cnt), TW'(nreq));
            check("busy", TW'(o_busy), TW'(1));
            req_cnt = 0;
            stall = $urandom_range(stall_min, stall_max);
            for (int i = 0; i < stall; i++) begin
               if (poke && i == 1) begin
                  cfg_k = K_W'(2); cfg_c = CH_W'(7); cfg_stride = 4'd3; cfg_base = AW'(16'h5555);
                  i_start = 1'b1;
               end
               tick();
               i_start = 1'b0;
               check("stall_valid", TW'(o_tile_valid), TW'(1));
               check("stall_data", o_tile, exp);
               check("stall_row", TW'(o_tile_row), TW'(rt));
               check("stall_col", TW'(o_tile_col), TW'(ct));
               check("stall_no_req", TW'(o_mem_req), TW'(0));
            end
            i_tile_ready = 1'b1;
            tick();
            i_tile_ready = 1'b0;
            if (last) begin
               check("done_pulse", TW'(o_done), TW'(1));
               check("busy_low_at_done", TW'(o_busy), TW'(0));
            end else begin
               check("valid_drops", TW'(o_tile_valid), TW'(0));
            end
         end
      end
      tick();
      tick();
      check("done_once", TW'(done_cnt), TW'(1));
   endtask

   logic [TW-1:0] g;
   int            g00 [16] = '{0,1,2,4, 1,2,3,5, 4,5,6,8, 5,6,7,9};
   int            t3a [8]  = '{'h100,'h119,'h102,'h11B,'h104,'h11D,'h10A,'h123};
   bit            ok;
   int            in_s, k, p, s, c;

   initial begin
      rstn = 1'b0; i_start = 1'b0; i_tile_ready = 1'b0;
      set_cfg(4, 2, 3, 1, 1, 0, 0);
      repeat (3) tick();
      check("rst_busy", TW'(o_busy), TW'(0));
      check("rst_valid", TW'(o_tile_valid), TW'(0));
      check("rst_req", TW'(o_mem_req), TW'(0));
      check("rst_done", TW'(o_done), TW'(0));
      check("rst_tile", o_tile, TW'(0));
      check("rst_addr", TW'(o_mem_addr), TW'(0));
      rstn = 1'b1;
      tick();

      // Small 3x3 kernel over a 4x4 image: three column tiles.
      set_cfg(4, 2, 3, 1, 1, 0, 0);
      run_job(0, 0, 1'b0);
      for (int i = 0; i < 16; i++) g[i*DW +: DW] = DW'(g00[i]);
      check("t1_tile00_golden", tile00, g);

      // Same job with a five-cycle stall per tile and an ignored start pulse.
      set_cfg(4, 2, 3, 1, 1, 0, 0);
      run_job(5, 5, 1'b1);

      // Padding P=1: first slots are all padding; first real read is address 0.
      set_cfg(3, 3, 3, 1, 1, 1, 0);
      run_job(0, 1, 1'b0);
      check("t2_elem00_zero", TW'(tile00[DW-1:0]), TW'(0));
      check("t2_first_addr", TW'(addr_q.size() > 0 ? addr_q[0] : AW'('1)), TW'(0));

      // 1x1 kernel, two channels, stride 2, nonzero base.
      set_cfg(5, 3, 1, 2, 2, 0, 'h100);
      run_job(0, 2, 1'b0);
      check("t3_addr_count", TW'(addr_q.size() >= 8), TW'(1));
      if (addr_q.size() >= 8)
         for (int i = 0; i < 8; i++) check("t3_addr", TW'(addr_q[i]), TW'(t3a[i]));

      // Reset in the middle of the second tile's issue phase.
      set_cfg(4, 2, 3, 1, 1, 0, 0);
      done_cnt = 0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      wait_valid(ok);
      check("mid_first_valid", TW'(ok), TW'(1));
      i_tile_ready = 1'b1;
      tick();
      i_tile_ready = 1'b0;
      repeat (6) tick();
      rstn = 1'b0;
      #1;
      check("mid_rst_busy", TW'(o_busy), TW'(0));
      check("mid_rst_req", TW'(o_mem_req), TW'(0));
      check("mid_rst_valid", TW'(o_tile_valid), TW'(0));
      check("mid_rst_tile", o_tile, TW'(0));
      check("mid_rst_addr", TW'(o_mem_addr), TW'(0));
      check("mid_rst_col", TW'(o_tile_col), TW'(0));
      repeat (2) tick();
      rstn = 1'b1;
      repeat (5) tick();
      check("mid_rst_no_done", TW'(done_cnt), TW'(0));
      set_cfg(4, 2, 3, 1, 1, 0, 0);
      run_job(0, 1, 1'b0);
      check("mid_rst_tile00_golden", tile00, g);

      // Random geometries.
      for (int j = 0; j < 15; j++) begin
         do begin
            in_s = $urandom_range(1, 6);
            k    = $urandom_range(1, 3);
            p    = $urandom_range(0, k-1);
         end while (in_s + 2*p < k);
         s = $urandom_range(1, 3);
         c = $urandom_range(1, 2);
         set_cfg(in_s, (in_s + 2*p - k)/s + 1, k, c, s, p, int'($urandom_range(0, 65535)));
         run_job(0, 2, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
